// File: rtl/mmul_pkg.sv
// rtl/mmul_pkg.sv - shared types, order codes and counter sizing for the index sequencer
package mmul_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic ORDER_IJK = 1'b0;
   localparam logic ORDER_IKJ = 1'b1;

   // A dimension of 1 still gets a 1-bit counter so every counter is legal.
   function automatic int cnt_width(input int dim);
      return (dim < 2) ? 1 : $clog2(dim);
   endfunction

endpackage

// File: rtl/mmul_wrap_counter.sv
// rtl/mmul_wrap_counter.sv - modulo-MAX index counter with synchronous clear
module mmul_wrap_counter
   import mmul_pkg::*;
#(
   parameter int MAX = 4,
   parameter int W   = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] value,
   output logic         at_max
);

   localparam logic [W-1:0] LAST = W'(MAX - 1);

   logic [W-1:0] value_q, value_d;

   assign at_max = (value_q == LAST);
   assign value  = value_q;

   always_comb begin
      value_d = value_q;
      if (clr) begin
         value_d = '0;
      end else if (inc) begin
         value_d = at_max ? '0 : value_q + W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         value_q <= '0;
      end else begin
         value_q <= value_d;
      end
   end

endmodule

// File: rtl/mmul_index_sequencer.sv
// rtl/mmul_index_sequencer.sv - generates the i/j/k loop nest of C = A*B under valid/ready
module mmul_index_sequencer
   import mmul_pkg::*;
#(
   parameter int RA = 4,
   parameter int CA = 4,
   parameter int RB = 4,
   parameter int CB = 4,
   parameter int IW = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          abort,
   input  logic          order,
   input  logic          ready,
   output logic          valid,
   output logic [IW-1:0] i,
   output logic [IW-1:0] j,
   output logic [IW-1:0] k,
   output logic          k_first,
   output logic          k_last,
   output logic          busy,
   output logic          completed,
   output logic          done
);

   localparam int WI = cnt_width(RA);
   localparam int WJ = cnt_width(CB);
   localparam int WK = cnt_width(RB);
   localparam logic [63:0] IDX_SPAN = 64'd1 << IW;

   if (RA < 1 || CA < 1 || RB < 1 || CB < 1) begin : g_err_zero_dim
      $error("mmul_index_sequencer: every dimension must be at least 1");
   end
   if (CA != RB) begin : g_err_inner_dim
      $error("mmul_index_sequencer: CA must equal RB");
   end
   if (64'(RA) > IDX_SPAN || 64'(RB) > IDX_SPAN || 64'(CB) > IDX_SPAN) begin : g_err_width
      $error("mmul_index_sequencer: a dimension does not fit in IW bits");
   end

   state_t state_q, state_d;
   logic   order_q, order_d;
   logic   done_q, done_d;

   logic [WI-1:0] i_cnt;
   logic [WJ-1:0] j_cnt;
   logic [WK-1:0] k_cnt;
   logic          i_max, j_max, k_max;
   logic          inc_i, inc_j, inc_k;
   logic          consume, last_tuple, launch, step, clr;

   assign consume    = (state_q == RUN) && ready;
   assign last_tuple = i_max && j_max && k_max;
   assign launch     = !abort && start && (state_q != RUN);
   // The final tuple is consumed without advancing so the indices hold it in DONE.
   assign step       = consume && !last_tuple && !abort;
   assign clr        = abort || launch;

   always_comb begin
      inc_i = 1'b0;
      inc_j = 1'b0;
      inc_k = 1'b0;
      if (order_q == ORDER_IJK) begin
         inc_k = step;
         inc_j = step && k_max;
         inc_i = step && k_max && j_max;
      end else begin
         inc_j = step;
         inc_k = step && j_max;
         inc_i = step && j_max && k_max;
      end
   end

   always_comb begin
      state_d = state_q;
      order_d = order_q;
      done_d  = 1'b0;
      if (abort) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE, DONE: begin
               if (start) begin
                  state_d = RUN;
                  order_d = order;
               end
            end
            RUN: begin
               if (consume && last_tuple) begin
                  state_d = DONE;
                  done_d  = 1'b1;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         order_q <= ORDER_IJK;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         order_q <= order_d;
         done_q  <= done_d;
      end
   end

   mmul_wrap_counter #(.MAX(RA), .W(WI)) u_cnt_i (
      .clk(clk), .rst(rst), .clr(clr), .inc(inc_i), .value(i_cnt), .at_max(i_max)
   );
   mmul_wrap_counter #(.MAX(CB), .W(WJ)) u_cnt_j (
      .clk(clk), .rst(rst), .clr(clr), .inc(inc_j), .value(j_cnt), .at_max(j_max)
   );
   mmul_wrap_counter #(.MAX(RB), .W(WK)) u_cnt_k (
      .clk(clk), .rst(rst), .clr(clr), .inc(inc_k), .value(k_cnt), .at_max(k_max)
   );

   assign valid     = (state_q == RUN);
   assign busy      = (state_q == RUN);
   assign completed = (state_q == DONE);
   assign done      = done_q;
   assign i         = IW'(i_cnt);
   assign j         = IW'(j_cnt);
   assign k         = IW'(k_cnt);
   assign k_first   = valid && (k_cnt == '0);
   assign k_last    = valid && k_max;

endmodule

// File: doc/mmul_index_sequencer.md
Name: mmul_index_sequencer

Overview:
- Parametrised successor to the matrix-multiply completion detector. Instead of watching externally generated i/j/k indices, this block generates them.
- Walks the full loop nest for C = A(RA x CA) * B(RB x CB) under a valid/ready handshake to the MAC datapath.
- Selectable loop order; accumulator first/last flags; sticky completion and a one-cycle done pulse.
- Sits between the top-level controller (start/abort) and the operand fetch / MAC pipeline.

Parameters:
- RA, 4: rows of A; outer index i range 0..RA-1.
- CA, 4: columns of A; must equal RB.
- RB, 4: rows of B; reduction index k range 0..RB-1.
- CB, 4: columns of B; index j range 0..CB-1.
- IW, 32: width of each index output.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin a new walk; sampled in IDLE or DONE only.
- abort  in  1  synchronous cancel; returns to IDLE.
- order  in  1  0 = i-j-k (k innermost); 1 = i-k-j (j innermost). Latched at start.
- ready  in  1  datapath accepts the current tuple.
- valid  out  1  current i/j/k tuple is valid.
- i  out  IW  row index of A.
- j  out  IW  column index of B.
- k  out  IW  reduction index.
- k_first  out  1  valid && k==0; clears the accumulator (meaningful in order 0).
- k_last  out  1  valid && k==RB-1; writes back C[i][j] (meaningful in order 0).
- busy  out  1  state == RUN.
- completed  out  1  sticky; high in DONE.
- done  out  1  single-cycle pulse on entry to DONE.

Behaviour:
- Reset: state=IDLE; i=j=k=0; valid=busy=completed=done=0; latched order=0.
- States: IDLE, RUN, DONE.
  - IDLE --start--> RUN.
  - RUN --final handshake--> DONE.
  - DONE --start--> RUN.
  - any --abort--> IDLE.
- Start handling:
  - start in IDLE/DONE: next cycle state=RUN, i=j=k=0, valid=1, completed=0, order latched.
  - start while in RUN is ignored.
- Handshake:
  - A tuple is consumed when valid && ready.
  - Indices advance only on consume. Without ready, the tuple and valid are held, with no bubbles or skips.
  - valid is registered and high for every RUN cycle. Each consume produces the next tuple on the following cycle, so throughput is 1 tuple/cycle under continuous ready.
- Advance for order 0:
  - k++. On k==RB-1, k wraps to 0 and j++.
  - On j==CB-1, j wraps to 0 and i++.
- Advance for order 1:
  - j++. On j==CB-1, j wraps to 0 and k++.
  - On k==RB-1, k wraps to 0 and i++.
- Final tuple: i==RA-1 && j==CB-1 && k==RB-1, identical for both orders.
  - On its consume: state=DONE, valid=0, completed=1, done=1 for exactly one cycle.
  - Indices hold the final tuple values.
- Tuple count: exactly RA*CB*RB tuples per walk, each (i,j,k) exactly once.
- Abort:
  - Takes priority over start and over the handshake in the same cycle.
  - Next cycle: IDLE, valid=0, completed=0, done=0, indices=0.
- Reset mid-walk: immediate return to reset values, asynchronously.
- Degenerate dimensions:
  - A dimension of 1 means that counter always wraps.
  - RA=CB=RB=1 gives a single-tuple walk: start, one consume, DONE.
- Widths and elaboration checks:
  - Internal counters are $clog2(max(dim,2)) bits, zero-extended to IW on output.
  - Elaboration error if any dimension is 0, if CA != RB, or if any dimension > 2**IW.

Decomposition:
- Package mmul_pkg:
  - state enum {IDLE, RUN, DONE};
  - order constants ORDER_IJK=1'b0, ORDER_IKJ=1'b1;
  - a function for counter width.
- Sub-module mmul_wrap_counter #(MAX, W):
  - ports: clk, rst, clr, inc; outputs: value, at_max.
  - Wraps to 0 when inc is asserted at MAX-1. Instantiated three times.
- Carry chaining (which counter's at_max gates which inc) is muxed by the latched order.

Test Plan:
- Basic ijk: RA=2, CB=2, RB=3, order=0, ready tied 1.
  - Expect 12 tuples in sequence: (0,0,0),(0,0,1),(0,0,2),(0,1,0)...(1,1,2).
  - k_first on every k=0 tuple, k_last on every k=2 tuple.
  - done pulses the cycle after the 12th consume; completed stays high.
- Order ikj, same dims, order=1.
  - Expect (0,0,0),(0,1,0),(0,0,1),(0,1,1)...; final tuple (1,1,2); 12 tuples total.
- Backpressure: ready toggles 1,0,0,1 repeating.
  - Tuple held stable while ready=0; no tuple duplicated or lost; a scoreboard sees all 12 unique tuples.
- Abort after the 5th consume.
  - Next cycle: valid=0, i=j=k=0, completed=0, no done pulse.
  - A following start restarts from (0,0,0).
- Restart from DONE, plus start asserted during RUN.
  - The mid-RUN start has no effect.
  - Start in DONE clears completed and re-walks the full 12 tuples.
- Async reset mid-walk and 1x1x1 config.
  - rst asserted between clock edges zeroes outputs immediately.
  - With RA=CB=RB=1: start, one consume with k_first=k_last=1, then done.
